// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-controller pipeline signals; master drives stage info, slave drives enables/flushes.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic        mem_branch_taken;
  logic        mem_jump;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_regwrite, ex_memtoreg,
           mem_rd, mem_regwrite, mem_branch_taken, mem_jump,
    input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, state, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_regwrite, ex_memtoreg,
           mem_rd, mem_regwrite, mem_branch_taken, mem_jump,
    output pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller with saturating event counters.
// Macro HAZ_FWD_EN: load-use-only hazard (forwarding present); default checks EX and MEM producers.
module pipe_hazard_ctrl (
  input logic clk,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
  state_t r_state;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic w_ex_match, w_mem_match, w_redirect, w_hazard, w_rule, w_stall;
  assign w_ex_match = (bus.ex_rd != 5'd0) &&
                      ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
                       (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
  assign w_mem_match = (bus.mem_rd != 5'd0) &&
                       ((bus.id_rs1_used && bus.id_rs1 == bus.mem_rd) ||
                        (bus.id_rs2_used && bus.id_rs2 == bus.mem_rd));
`ifdef HAZ_FWD_EN
  assign w_rule = bus.ex_regwrite && bus.ex_memtoreg && w_ex_match;
`else
  assign w_rule = (bus.ex_regwrite && w_ex_match) || (bus.mem_regwrite && w_mem_match);
  logic w_unused;
  assign w_unused = bus.ex_memtoreg;
`endif
  assign w_redirect = bus.mem_branch_taken || bus.mem_jump;
  assign w_hazard   = (r_state != FLUSH) && w_rule;
  assign w_stall    = !w_redirect && w_hazard;
  always_comb begin
    bus.pc_en       = !reset && !w_stall;
    bus.ifid_en     = !reset && !w_stall;
    bus.ifid_flush  = reset || w_redirect;
    bus.idex_flush  = reset || w_redirect || w_hazard;
    bus.exmem_flush = reset || w_redirect;
    bus.state       = (r_state == STALL || r_state == FLUSH) ? r_state : RUN;
    bus.stall_cnt   = r_stall_cnt;
    bus.flush_cnt   = r_flush_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state     <= w_redirect ? FLUSH : w_hazard ? STALL : RUN;
      r_stall_cnt <= (w_stall && r_stall_cnt != 16'hFFFF) ? r_stall_cnt + 16'd1 : r_stall_cnt;
      r_flush_cnt <= (w_redirect && r_flush_cnt != 16'hFFFF) ? r_flush_cnt + 16'd1 : r_flush_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, directed corner sequences and randomized model comparison.
module tb_pipe_hazard_ctrl;
  logic clk = 0;
  logic reset = 1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if bus();
  pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] exrd;
    logic exrw, exm2r;
    logic [4:0] memrd;
    logic memrw, br, jmp;
  } vin_t;
  typedef struct {
    string nm;
    vin_t v;
    logic [4:0] o;
    logic [1:0] ns;
  } vec_t;

  logic [4:0] dut_o;
  assign dut_o = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush, bus.exmem_flush};

  function automatic vin_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] exrd, logic exrw, logic exm2r,
                              logic [4:0] memrd, logic memrw, logic br, logic jmp);
    vin_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exrd = exrd; v.exrw = exrw;
    v.exm2r = exm2r; v.memrd = memrd; v.memrw = memrw; v.br = br; v.jmp = jmp;
    return v;
  endfunction

  task automatic drive(input vin_t v);
    bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2; bus.id_rs1_used = v.u1; bus.id_rs2_used = v.u2;
    bus.ex_rd = v.exrd; bus.ex_regwrite = v.exrw; bus.ex_memtoreg = v.exm2r;
    bus.mem_rd = v.memrd; bus.mem_regwrite = v.memrw;
    bus.mem_branch_taken = v.br; bus.mem_jump = v.jmp;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: spec rules stated directly on the set of sources read and producers in flight
  function automatic bit reads(vin_t v, logic [4:0] r);
    return r != 0 && ((v.u1 && v.rs1 == r) || (v.u2 && v.rs2 == r));
  endfunction
  function automatic bit m_hazard(vin_t v, int st);
    if (st == 2) return 0;
`ifdef HAZ_FWD_EN
    return v.exrw && v.exm2r && reads(v, v.exrd);
`else
    return (v.exrw && reads(v, v.exrd)) || (v.memrw && reads(v, v.memrd));
`endif
  endfunction
  function automatic logic [4:0] m_out(vin_t v, int st, bit rst);
    if (rst) return 5'b00111;
    if (v.br || v.jmp) return 5'b11111;
    if (m_hazard(v, st)) return 5'b00010;
    return 5'b11000;
  endfunction

  vec_t vecs[9];
  vin_t idle, lu, cur;
  int m_st, m_sc, m_fc;
  bit rst_r;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu   = mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0);
    vecs[0] = '{"idle",       idle,                                   5'b11000, 2'd0};
    vecs[1] = '{"load_use",   lu,                                     5'b00010, 2'd1};
    vecs[2] = '{"x0_load",    mk(0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0),   5'b11000, 2'd0};
`ifdef HAZ_FWD_EN
    vecs[3] = '{"ex_alu_rs2", mk(1, 7, 0, 1, 7, 1, 0, 0, 0, 0, 0),   5'b11000, 2'd0};
    vecs[4] = '{"mem_match",  mk(9, 0, 1, 0, 0, 0, 0, 9, 1, 0, 0),   5'b11000, 2'd0};
`else
    vecs[3] = '{"ex_alu_rs2", mk(1, 7, 0, 1, 7, 1, 0, 0, 0, 0, 0),   5'b00010, 2'd1};
    vecs[4] = '{"mem_match",  mk(9, 0, 1, 0, 0, 0, 0, 9, 1, 0, 0),   5'b00010, 2'd1};
`endif
    vecs[5] = '{"br_over_lu", mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 1, 0),   5'b11111, 2'd2};
    vecs[6] = '{"jump",       mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),   5'b11111, 2'd2};
    vecs[7] = '{"unused_src", mk(5, 5, 0, 0, 5, 1, 1, 5, 1, 0, 0),   5'b11000, 2'd0};
    vecs[8] = '{"mem_no_wr",  mk(9, 0, 1, 0, 0, 0, 0, 9, 0, 0, 0),   5'b11000, 2'd0};

    // reset behaviour with a live load-use and branch on the inputs
    drive(vecs[5].v);
    #1;
    chk("rst_outputs", {27'd0, dut_o}, {27'd0, 5'b00111});
    tick(); tick();
    chk("rst_state", {30'd0, bus.state}, 0);
    chk("rst_stall_cnt", {16'd0, bus.stall_cnt}, 0);
    chk("rst_flush_cnt", {16'd0, bus.flush_cnt}, 0);

    foreach (vecs[i]) begin
      reset = 1; drive(idle); tick();
      reset = 0; drive(vecs[i].v); #1;
      chk({vecs[i].nm, "_out"}, {27'd0, dut_o}, {27'd0, vecs[i].o});
      tick();
      chk({vecs[i].nm, "_state"}, {30'd0, bus.state}, {30'd0, vecs[i].ns});
    end

    // load-use: one stall, then RUN once the load moves on
    reset = 1; drive(idle); tick(); reset = 0;
    drive(lu); #1;
    chk("lu_pc_en", {31'd0, bus.pc_en}, 0);
    tick();
    chk("lu_state", {30'd0, bus.state}, 1);
    chk("lu_stall_cnt", {16'd0, bus.stall_cnt}, 1);
    drive(mk(5, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0)); tick();
    chk("lu_after_state", {30'd0, bus.state}, 0);
    chk("lu_after_cnt", {16'd0, bus.stall_cnt}, 1);

    // x0 never stalls
    drive(mk(0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0)); #1;
    chk("x0_pc_en", {31'd0, bus.pc_en}, 1);
    tick();
    chk("x0_stall_cnt", {16'd0, bus.stall_cnt}, 1);

`ifndef HAZ_FWD_EN
    // ALU producer of x7 seen in EX, then MEM: two stalls
    reset = 1; drive(idle); tick(); reset = 0;
    drive(mk(7, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0)); tick();
    drive(mk(7, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0)); #1;
    chk("alu2_mem_pc_en", {31'd0, bus.pc_en}, 0);
    tick();
    drive(mk(7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); #1;
    chk("alu2_free_pc_en", {31'd0, bus.pc_en}, 1);
    tick();
    chk("alu2_stall_cnt", {16'd0, bus.stall_cnt}, 2);
    chk("alu2_state", {30'd0, bus.state}, 0);
`endif

    // redirect beats hazard; hazard suppressed in FLUSH; back-to-back redirects
    reset = 1; drive(idle); tick(); reset = 0;
    cur = lu; cur.br = 1; drive(cur); #1;
    chk("redir_out", {27'd0, dut_o}, {27'd0, 5'b11111});
    tick();
    chk("redir_state", {30'd0, bus.state}, 2);
    chk("redir_flush_cnt", {16'd0, bus.flush_cnt}, 1);
    chk("redir_stall_cnt", {16'd0, bus.stall_cnt}, 0);
    drive(lu); #1;
    chk("flush_masks_haz", {27'd0, dut_o}, {27'd0, 5'b11000});
    tick();
    chk("flush_exit_state", {30'd0, bus.state}, 0);
    chk("flush_exit_stall", {16'd0, bus.stall_cnt}, 0);
    cur = idle; cur.jmp = 1; drive(cur); tick(); tick();
    chk("b2b_state", {30'd0, bus.state}, 2);
    chk("b2b_flush_cnt", {16'd0, bus.flush_cnt}, 3);
    drive(idle); tick();
    chk("b2b_exit", {30'd0, bus.state}, 0);

    // reset mid-stall
    drive(lu); tick();
    chk("mid_stall_state", {30'd0, bus.state}, 1);
    reset = 1; #1;
    chk("mid_rst_out", {27'd0, dut_o}, {27'd0, 5'b00111});
    tick();
    chk("mid_rst_state", {30'd0, bus.state}, 0);
    chk("mid_rst_cnts", {bus.stall_cnt, bus.flush_cnt}, 0);
    reset = 0; drive(idle); tick();

    // stall counter saturation
    drive(lu);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre", {16'd0, bus.stall_cnt}, 32'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, bus.stall_cnt}, 32'hFFFF);
    chk("sat_pc_en", {31'd0, bus.pc_en}, 0);

    // randomized comparison against the model
    reset = 1; drive(idle); tick();
    m_st = 0; m_sc = 0; m_fc = 0;
    for (int n = 0; n < 800; n++) begin
      rst_r = ($urandom_range(0, 39) == 0);
      cur = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      reset = rst_r; drive(cur); #1;
      chk("rnd_out", {27'd0, dut_o}, {27'd0, m_out(cur, m_st, rst_r)});
      if (rst_r) begin
        m_st = 0; m_sc = 0; m_fc = 0;
      end else if (cur.br || cur.jmp) begin
        m_st = 2; m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
      end else if (m_hazard(cur, m_st)) begin
        m_st = 1; m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
      end else m_st = 0;
      tick();
      chk("rnd_state", {30'd0, bus.state}, m_st);
      chk("rnd_stall_cnt", {16'd0, bus.stall_cnt}, m_sc);
      chk("rnd_flush_cnt", {16'd0, bus.flush_cnt}, m_fc);
    end
    reset = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
